// File: rtl/alu_disp_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : alu_disp_pkg                                                 |
// | Description : Shared constants, FSM state type and BCD-to-segment helper   |
// |               for the ALU result display. Segment order is {g,f,e,d,c,b,a},|
// |               active-low.                                                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_disp_pkg;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_C     = 7'b1000110;

  // Synchronized input tuple layout: {p1, p2, c, e[3:0], m[7:0]}
  localparam int TUPLE_W = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  // Non-decimal nibbles never occur from the converter; map them to blank.
  function automatic logic [6:0] seg_of_bcd(input logic [3:0] bcd);
    logic [6:0] s;
    s = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (bcd == 4'(i)) s = SEG_DIGIT[i];
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_8b.sv
// +----------------------------------------------------------------------------+
// | Module      : bin2bcd_8b                                                   |
// | Description : Sequential double-dabble converter, 8-bit binary to 3 BCD    |
// |               digits, one shift per clock (8 clocks per conversion).       |
// | Ports       : clk, rst (async, active-high)                                |
// |               i_start  - load i_bin and begin converting                   |
// |               i_bin    - 8-bit binary operand                              |
// |               o_busy   - conversion shifts in progress                     |
// |               o_done   - high during the cycle of the final shift          |
// |               o_bcd    - {hundreds, tens, ones}, valid once busy drops     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module bin2bcd_8b
  import alu_disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [7:0]  i_bin,
  output logic        o_busy,
  output logic        o_done,
  output logic [11:0] o_bcd
);

  // {bcd[11:0], remaining binary bits[7:0]}
  logic [19:0] r_shift;
  logic [2:0]  r_cnt;
  logic        r_busy;
  logic [19:0] w_adj;

  // Add-3 correction on every BCD nibble that would overflow past 9 after doubling.
  always_comb begin
    w_adj = r_shift;
    for (int k = 0; k < 3; k++) begin
      if (r_shift[8 + 4*k +: 4] >= 4'd5)
        w_adj[8 + 4*k +: 4] = r_shift[8 + 4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (i_start) begin
      r_shift <= {12'd0, i_bin};
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      r_shift <= {w_adj[18:0], 1'b0};
      r_cnt   <= r_cnt + 3'd1;
      if (r_cnt == 3'd7) r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == 3'd7);
  assign o_bcd  = r_shift[19:8];

endmodule

`default_nettype wire

// File: rtl/alu_result_display.sv
// +----------------------------------------------------------------------------+
// | Module      : alu_result_display                                           |
// | Description : Converts the selected ALU result to decimal and drives a     |
// |               4-digit multiplexed common-anode display (ones, tens,        |
// |               hundreds, status).                                           |
// | Ports       : clk, rst (async, active-high)                                |
// |               i_m[7:0] product, i_e[3:0] add/sub/div result,               |
// |               i_c carry/borrow or divide-by-zero, i_p1/i_p2 op select      |
// |               o_seg[6:0] {g..a} active-low, o_an[3:0] active-low enables,  |
// |               o_busy conversion in flight                                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_result_display
  import alu_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_m,
  input  logic [3:0] i_e,
  input  logic       i_c,
  input  logic       i_p1,
  input  logic       i_p2,
  output logic [6:0] o_seg,
  output logic [3:0] o_an,
  output logic       o_busy
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] c_PRESC_MAX = PW'(REFRESH_DIV - 1);

  // ---------------------------------------------------------------- sync
  logic [TUPLE_W-1:0] r_sync1, r_sync2;
  logic [TUPLE_W-1:0] w_tuple;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {i_p1, i_p2, i_c, i_e, i_m};
      r_sync2 <= r_sync1;
    end
  end

  assign w_tuple = r_sync2;

  // ---------------------------------------------------------------- control
  state_t             r_state;
  logic [TUPLE_W-1:0] r_last;
  logic               r_valid;
  logic               r_busy;
  logic               r_start;
  logic [3:0][6:0]    r_disp;

  logic [7:0]      w_val;
  logic            w_eng_busy;
  logic            w_eng_done;
  logic [11:0]     w_bcd;
  logic [3:0][6:0] w_next_disp;

  // Multiply shows the 8-bit product; every other op shows the 4-bit result.
  assign w_val = (r_last[14:13] == 2'b10) ? r_last[7:0] : {4'd0, r_last[11:8]};

  bin2bcd_8b u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (r_start),
    .i_bin   (w_val),
    .o_busy  (w_eng_busy),
    .o_done  (w_eng_done),
    .o_bcd   (w_bcd)
  );

  // Leading-zero blanking, carry indicator and divide-by-zero override.
  always_comb begin
    w_next_disp[0] = seg_of_bcd(w_bcd[3:0]);
    w_next_disp[1] = (w_bcd[11:4] == 8'd0) ? SEG_BLANK : seg_of_bcd(w_bcd[7:4]);
    w_next_disp[2] = (w_bcd[11:8] == 4'd0) ? SEG_BLANK : seg_of_bcd(w_bcd[11:8]);
    w_next_disp[3] = (!r_last[14] && r_last[12]) ? SEG_C : SEG_BLANK;
    if (r_last[14] && r_last[13] && r_last[12]) begin
      w_next_disp = {4{SEG_DASH}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_disp  <= {4{SEG_BLANK}};
    end else begin
      r_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_valid || (w_tuple != r_last)) begin
            r_last  <= w_tuple;
            r_busy  <= 1'b1;
            r_start <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_state <= CONV;
        end
        CONV: begin
          if (w_eng_done) begin
            r_busy  <= 1'b0;
            r_state <= DONE;
          end else if (!w_eng_busy) begin
            // Engine idle without finishing: drop this attempt and retry from IDLE.
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        DONE: begin
          r_disp  <= w_next_disp;
          r_valid <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy = r_busy;

  // ---------------------------------------------------------------- scanner
  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;

  // Enable and segments are registered from the same index so they always agree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_an    <= 4'b1111;
      r_seg   <= SEG_BLANK;
    end else begin
      if (r_presc == c_PRESC_MAX) begin
        r_presc <= '0;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= r_disp[r_idx];
    end
  end

  assign o_an  = r_an;
  assign o_seg = r_seg;

endmodule

`default_nettype wire

// File: tb/tb_alu_result_display.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_result_display                                        |
// | Description : Self-checking bench for alu_result_display (REFRESH_DIV=4).  |
// |               Expected digits come from a decimal-arithmetic model.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_result_display;

  localparam int RD = 4;

  localparam logic [6:0] DIGS [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] CCHR  = 7'b1000110;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] m   = '0;
  logic [3:0] e   = '0;
  logic       c   = 1'b0;
  logic       p1  = 1'b0;
  logic       p2  = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  alu_result_display #(.REFRESH_DIV(RD)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_m    (m),
    .i_e    (e),
    .i_c    (c),
    .i_p1   (p1),
    .i_p2   (p2),
    .o_seg  (seg),
    .o_an   (an),
    .o_busy (busy)
  );

  always #5 clk = ~clk;

  // Expected {digit3, digit2, digit1, digit0} segment patterns.
  function automatic logic [27:0] model(input logic mp1, input logic mp2, input logic mc,
                                        input logic [3:0] me, input logic [7:0] mm);
    int v, o, t, h;
    logic [6:0] d0, d1, d2, d3;
    if (mp1 && mp2 && mc) return {4{DASH}};
    v  = (mp1 && !mp2) ? int'(mm) : int'(me);
    o  = v % 10;
    t  = (v / 10) % 10;
    h  = v / 100;
    d0 = DIGS[o];
    d1 = (h == 0 && t == 0) ? BLANK : DIGS[t];
    d2 = (h == 0) ? BLANK : DIGS[h];
    d3 = (!mp1 && mc) ? CCHR : BLANK;
    return {d3, d2, d1, d0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic a1, input logic a2, input logic ac,
                       input logic [3:0] ae, input logic [7:0] am);
    p1 = a1; p2 = a2; c = ac; e = ae; m = am;
  endtask

  // Clock edges until busy reaches lvl (bounded).
  task automatic cycles_until(input logic lvl, output int n);
    n = 0;
    while (busy !== lvl && n < 64) begin
      tick();
      n++;
    end
  endtask

  // Observe one full scan round starting at the first cycle of the digit-0 slot.
  task automatic check_display(input string tag, input logic [27:0] ex);
    int n;
    n = 0;
    while (an === 4'b1110 && n < 64) begin tick(); n++; end
    n = 0;
    while (an !== 4'b1110 && n < 64) begin tick(); n++; end
    chk({tag, "_scan_start"}, {28'd0, an}, 32'h0000000E);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < RD; j++) begin
        chk({tag, "_an"}, {28'd0, an}, {28'd0, ~(4'b0001 << k)});
        chk({tag, "_seg"}, {25'd0, seg}, {25'd0, ex[k*7 +: 7]});
        tick();
      end
    end
  endtask

  // Full conversion: LOAD on the third edge after the change, busy for 9 clocks.
  task automatic convert_and_check(input string tag, input logic a1, input logic a2,
                                   input logic ac, input logic [3:0] ae, input logic [7:0] am);
    int n;
    apply(a1, a2, ac, ae, am);
    cycles_until(1'b1, n);
    chk({tag, "_latency"}, n, 3);
    cycles_until(1'b0, n);
    chk({tag, "_busy_len"}, n, 9);
    check_display(tag, model(a1, a2, ac, ae, am));
  endtask

  initial begin
    int n;
    logic [14:0] prev, cur;
    logic [14:0] b2b;

    // Reset values take effect immediately.
    #2 rst = 1'b1;
    #1;
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_busy", {31'd0, busy}, 0);
    tick(); tick();
    rst = 1'b0;

    // Forced first conversion of the all-zero input.
    cycles_until(1'b1, n);
    chk("init_rise", {31'd0, (n < 64)}, 1);
    cycles_until(1'b0, n);
    chk("init_busy_len", n, 9);
    check_display("init", model(1'b0, 1'b0, 1'b0, 4'd0, 8'd0));

    convert_and_check("mul225", 1'b1, 1'b0, 1'b0, 4'd0, 8'd225);
    convert_and_check("mul255", 1'b1, 1'b0, 1'b0, 4'd0, 8'd255);
    convert_and_check("add3c1", 1'b0, 1'b0, 1'b1, 4'd3, 8'd0);
    convert_and_check("add3c0", 1'b0, 1'b0, 1'b0, 4'd3, 8'd0);
    convert_and_check("divzero", 1'b1, 1'b1, 1'b1, 4'd0, 8'd0);

    // Randomized tuples, each distinct from its predecessor.
    b2b  = {2'b10, 1'b1, 4'hA, 8'd99};
    prev = {2'b11, 1'b1, 4'd0, 8'd0};
    for (int i = 0; i < 10; i++) begin
      do begin
        cur = 15'($urandom);
      end while (cur == prev || cur == b2b);
      prev = cur;
      convert_and_check("rand", cur[14], cur[13], cur[12], cur[11:8], cur[7:0]);
    end

    // Input changes three clocks into CONV: 99 completes, one IDLE clock, then 100.
    apply(1'b1, 1'b0, 1'b1, 4'hA, 8'd99);
    cycles_until(1'b1, n);
    chk("b2b_latency", n, 3);
    repeat (4) tick();
    m = 8'd100;
    cycles_until(1'b0, n);
    chk("b2b_first_end", n, 5);
    cycles_until(1'b1, n);
    chk("b2b_gap", n, 2);
    cycles_until(1'b0, n);
    chk("b2b_second_len", n, 9);
    check_display("b2b", model(1'b1, 1'b0, 1'b1, 4'hA, 8'd100));

    // Reset during CONV: immediate reset outputs, then a forced fresh conversion.
    apply(1'b0, 1'b0, 1'b1, 4'd9, 8'd17);
    cycles_until(1'b1, n);
    chk("rstconv_latency", n, 3);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("rstconv_an", {28'd0, an}, 32'hF);
    chk("rstconv_seg", {25'd0, seg}, 32'h7F);
    chk("rstconv_busy", {31'd0, busy}, 0);
    tick(); tick();
    rst = 1'b0;
    cycles_until(1'b1, n);
    chk("rstconv_forced", {31'd0, (n <= 3)}, 1);
    repeat (40) tick();
    check_display("rstconv", model(1'b0, 1'b0, 1'b1, 4'd9, 8'd17));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
